// File: rtl/bus_sequencer.sv
// bus_sequencer: takes the 6502 off the bus and runs one RAM or I/O bus cycle on the pads.
// Optional feature macro BUS_SEQUENCER_BURST_EN: start a new cycle straight from HOLD.
module bus_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 17,
    parameter int NUM_CS        = 3,
    parameter int TURN_CYCLES   = 1,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    localparam int TW = $clog2(NUM_CS + 1)
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  we_i,
    input  logic [TW-1:0]         target_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  cpu_be_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH-1:0] addr_oe,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] data_oe,
    output logic                  ram_oe_n_o,
    output logic                  ram_we_n_o,
    output logic                  io_oe_n_o,
    output logic [NUM_CS-1:0]     cs_n_o
);

    localparam int MAX_TS = (TURN_CYCLES > SETUP_CYCLES) ? TURN_CYCLES : SETUP_CYCLES;
    localparam int MAXP   = (MAX_TS > STROBE_CYCLES) ? MAX_TS : STROBE_CYCLES;
    localparam int CW     = $clog2(MAXP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RELEASE, S_SETUP, S_STROBE, S_HOLD, S_TURN
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [TW-1:0]         tgt_q, tgt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  cpu_be_q, cpu_be_d, ready_q, ready_d, done_q, done_d;
    logic                  aoe_q, aoe_d, doe_q, doe_d;
    logic                  ram_oe_n_q, ram_oe_n_d, ram_we_n_q, ram_we_n_d, io_oe_n_q, io_oe_n_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  last_s, strobe_s;

    function automatic logic tgt_legal(input logic [TW-1:0] t);
        return int'(t) <= NUM_CS;
    endfunction

    assign last_s = (cnt_q == '0);

    // Next state, phase counter, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = last_s ? cnt_q : cnt_q - CW'(1);
        we_d    = we_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RELEASE;
                    cnt_d   = CW'(TURN_CYCLES);
                    we_d    = we_i;
                    tgt_d   = target_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (last_s) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYCLES - 1);
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_SETUP: begin
                if (last_s) begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(STROBE_CYCLES - 1);
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_STROBE: begin
                if (last_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    // Reads to a non-existent select complete with zero data.
                    if (!we_q) begin
                        rdata_d = tgt_legal(tgt_q) ? data_i : '0;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = S_STROBE;
                end
            end
            S_HOLD: begin
`ifdef BUS_SEQUENCER_BURST_EN
                if (start_i) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYCLES - 1);
                    we_d    = we_i;
                    tgt_d   = target_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = CW'(TURN_CYCLES - 1);
                end
`else
                state_d = S_TURN;
                cnt_d   = CW'(TURN_CYCLES - 1);
`endif
            end
            S_TURN: begin
                if (last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TURN;
                end
            end
            default: begin
                state_d = S_TURN;
                cnt_d   = CW'(TURN_CYCLES);
            end
        endcase
    end

    // Pin values for the upcoming state, so every output leaves a flop.
    always_comb begin
        cpu_be_d = (state_d == S_IDLE);
`ifdef BUS_SEQUENCER_BURST_EN
        ready_d  = (state_d == S_IDLE) || (state_d == S_HOLD);
`else
        ready_d  = (state_d == S_IDLE);
`endif
        done_d     = (state_d == S_HOLD);
        aoe_d      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        doe_d      = aoe_d && we_d;
        strobe_s   = (state_d == S_STROBE) && tgt_legal(tgt_d);
        ram_oe_n_d = !(strobe_s && (tgt_d == '0) && !we_d);
        ram_we_n_d = !(strobe_s && (tgt_d == '0) && we_d);
        io_oe_n_d  = !(strobe_s && (tgt_d != '0) && !we_d);
        cs_n_d     = '1;
        for (int k = 0; k < NUM_CS; k++) begin
            cs_n_d[k] = !(strobe_s && (int'(tgt_d) == k + 1));
        end
    end

    // State and output registers; reset parks the sequencer in TURN with the CPU off the bus.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_TURN;
            cnt_q      <= CW'(TURN_CYCLES);
            we_q       <= 1'b0;
            tgt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cpu_be_q   <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            aoe_q      <= 1'b0;
            doe_q      <= 1'b0;
            ram_oe_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            io_oe_n_q  <= 1'b1;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cpu_be_q   <= cpu_be_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            aoe_q      <= aoe_d;
            doe_q      <= doe_d;
            ram_oe_n_q <= ram_oe_n_d;
            ram_we_n_q <= ram_we_n_d;
            io_oe_n_q  <= io_oe_n_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
    assign cpu_be_o   = cpu_be_q;
    assign addr_o     = addr_q;
    assign addr_oe    = {ADDR_WIDTH{aoe_q}};
    assign data_o     = wdata_q;
    assign data_oe    = {DATA_WIDTH{doe_q}};
    assign ram_oe_n_o = ram_oe_n_q;
    assign ram_we_n_o = ram_we_n_q;
    assign io_oe_n_o  = io_oe_n_q;
    assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: timeline model of the bus cycle plus directed transactions.
// A second instance with NUM_CS=2 exercises the out-of-range target path.
module tb_bus_sequencer;

`ifdef BUS_SEQUENCER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int T = 1, S = 2, W = 4;
    localparam int DONE_N = T + S + W + 1;
    localparam int IDLE_N = 2 * T + S + W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, we;
    logic [1:0]  target;
    logic [16:0] addr;
    logic [7:0]  wdata, data_in;

    logic        ready, done, cpu_be, ram_oe_n, ram_we_n, io_oe_n;
    logic [7:0]  rdata, data_o, data_oe;
    logic [16:0] addr_o, addr_oe;
    logic [2:0]  cs_n;

    logic        s_ready, s_done, s_cpu_be, s_ram_oe_n, s_ram_we_n, s_io_n;
    logic [7:0]  s_rdata, s_data_o, s_data_oe;
    logic [16:0] s_addr_o, s_addr_oe;
    logic [1:0]  s_cs_n;

    bus_sequencer dut (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start), .we_i(we), .target_i(target),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .done_o(done), .rdata_o(rdata),
        .cpu_be_o(cpu_be), .addr_o(addr_o), .addr_oe(addr_oe), .data_i(data_in),
        .data_o(data_o), .data_oe(data_oe), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n),
        .io_oe_n_o(io_oe_n), .cs_n_o(cs_n)
    );

    bus_sequencer #(.NUM_CS(2)) dut2 (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start), .we_i(we), .target_i(target),
        .addr_i(addr), .wdata_i(wdata), .ready_o(s_ready), .done_o(s_done), .rdata_o(s_rdata),
        .cpu_be_o(s_cpu_be), .addr_o(s_addr_o), .addr_oe(s_addr_oe), .data_i(data_in),
        .data_o(s_data_o), .data_oe(s_data_oe), .ram_oe_n_o(s_ram_oe_n), .ram_we_n_o(s_ram_we_n),
        .io_oe_n_o(s_io_n), .cs_n_o(s_cs_n)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: m_n counts edges since the cycle began; all pins follow from the timeline.
    int          m_n;
    logic        m_rst, m_we;
    logic [1:0]  m_tgt;
    logic [16:0] m_addr;
    logic [7:0]  m_wd, m_rd, m_rd2;

    wire e_be   = (m_n >= IDLE_N);
    wire e_rdy  = e_be || (BURST && m_n == DONE_N && !m_rst);
    wire e_aoe  = !m_rst && m_n >= T + 1 && m_n <= DONE_N;
    wire e_doe  = e_aoe && m_we;
    wire e_stb  = !m_rst && m_n >= T + S + 1 && m_n <= T + S + W;
    wire e_done = !m_rst && m_n == DONE_N;
    wire e_ram_oe_n = !(e_stb && m_tgt == 2'd0 && !m_we);
    wire e_ram_we_n = !(e_stb && m_tgt == 2'd0 && m_we);
    wire e_io_n  = !(e_stb && !m_we && m_tgt != 2'd0);
    wire e2_io_n = !(e_stb && !m_we && m_tgt != 2'd0 && m_tgt <= 2'd2);
    wire [2:0] e_cs_n  = {!(e_stb && m_tgt == 2'd3), !(e_stb && m_tgt == 2'd2), !(e_stb && m_tgt == 2'd1)};
    wire [1:0] e2_cs_n = {!(e_stb && m_tgt == 2'd2), !(e_stb && m_tgt == 2'd1)};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= DONE_N; m_rst <= 1'b1; m_we <= 1'b0; m_tgt <= 2'd0;
            m_addr <= 17'h0; m_wd <= 8'h0; m_rd <= 8'h0; m_rd2 <= 8'h0;
        end else begin
            if (start && e_rdy) begin
                m_n <= (m_n == DONE_N) ? T + 1 : 0;
                m_rst <= 1'b0; m_we <= we; m_tgt <= target; m_addr <= addr; m_wd <= wdata;
            end else if (m_n < IDLE_N) begin
                m_n <= m_n + 1;
            end
            if (!m_rst && !m_we && m_n == T + S + W) begin
                m_rd  <= data_in;
                m_rd2 <= (m_tgt <= 2'd2) ? data_in : 8'h00;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_be", cpu_be, e_be);
            check("ready", ready, e_rdy);
            check("done", done, e_done);
            check("addr_oe", addr_oe, {17{e_aoe}});
            check("data_oe", data_oe, {8{e_doe}});
            check("ram_oe_n", ram_oe_n, e_ram_oe_n);
            check("ram_we_n", ram_we_n, e_ram_we_n);
            check("io_oe_n", io_oe_n, e_io_n);
            check("cs_n", cs_n, e_cs_n);
            check("rdata", rdata, m_rd);
            check("be_oe_overlap", cpu_be && (addr_oe[0] || data_oe[0]), 1'b0);
            if (e_aoe) check("addr_o", addr_o, m_addr);
            if (e_doe) check("data_o", data_o, m_wd);
            check("s_cs_n", s_cs_n, e2_cs_n);
            check("s_io_oe_n", s_io_n, e2_io_n);
            check("s_done", s_done, e_done);
            check("s_rdata", s_rdata, m_rd2);
        end
    end

    int done_cnt, done1, done2, we_lo, oe_lo, cs_lo, io_lo, be_first, aoe_cnt, pin_bad;
    int s_stb, s_done_cnt;
    logic [2:0] cs_seen;
    logic [7:0] rd_done, s_rd;

    task automatic wait_ready();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 40);
        check("ready_wait", ready, 1'b1);
    endtask

    task automatic xact(input logic w, input logic [1:0] t, input logic [16:0] a,
                        input logic [7:0] d, input bit burst2);
        done_cnt = 0; done1 = -1; done2 = -1; we_lo = 0; oe_lo = 0; cs_lo = 0; io_lo = 0;
        be_first = -1; aoe_cnt = 0; pin_bad = 0; s_stb = 0; s_done_cnt = 0;
        cs_seen = 3'b111; rd_done = 8'h00; s_rd = 8'h00;
        wait_ready();
        start = 1'b1; we = w; target = t; addr = a; wdata = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (burst2 && n == DONE_N) begin
                start = 1'b1; we = 1'b1; target = 2'd0; addr = 17'h0ABCD; wdata = 8'h5A;
            end
            if (burst2 && n == DONE_N + 1) start = 1'b0;
            if (!ram_we_n) we_lo++;
            if (!ram_oe_n) oe_lo++;
            if (!io_oe_n) io_lo++;
            if (cs_n != 3'b111) begin cs_lo++; cs_seen = cs_n; end
            if (cpu_be && be_first < 0) be_first = n;
            if (addr_oe[0]) aoe_cnt++;
            if (n <= DONE_N && addr_oe[0] && (addr_o !== a || (w && data_o !== d))) pin_bad++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done1 = n; else done2 = n;
                rd_done = rdata;
            end
            if (s_cs_n != 2'b11 || !s_ram_oe_n || !s_ram_we_n || !s_io_n) s_stb++;
            if (s_done) begin s_done_cnt++; s_rd = s_rdata; end
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("be_after_edge1", cpu_be, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("be_after_edge2", cpu_be, 1'b1);
        check("ready_after_edge2", ready, 1'b1);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_cpu_be"}, cpu_be, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_addr_oe"}, addr_oe, 17'h0);
        check({tag, "_data_oe"}, data_oe, 8'h0);
        check({tag, "_strobes"}, {ram_oe_n, ram_we_n, io_oe_n, cs_n}, 6'b111111);
        check({tag, "_rdata"}, rdata, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; we = 1'b0; target = 2'd0;
        addr = 17'h0; wdata = 8'h0; data_in = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_reset_pins("reset");
        release_reset();

        // RAM write 0x1_8000 <- 0xA5
        xact(1'b1, 2'd0, 17'h18000, 8'hA5, 1'b0);
        check("wr_we_lo_cycles", we_lo, 4);
        check("wr_done_at", done1, 8);
        check("wr_ready_at", be_first, 10);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_aoe_cycles", aoe_cnt, 7);
        check("wr_pins_stable", pin_bad, 0);
        check("wr_other_strobes", oe_lo + cs_lo + io_lo, 0);

        // I/O read from select 2
        data_in = 8'h3C;
        xact(1'b0, 2'd2, 17'h00456, 8'h00, 1'b0);
        check("io_cs_lo_cycles", cs_lo, 4);
        check("io_cs_value", cs_seen, 3'b101);
        check("io_oe_lo_cycles", io_lo, 4);
        check("io_rdata", rd_done, 8'h3C);
        check("io_ram_quiet", we_lo + oe_lo, 0);

        // target 3: the third select on the main instance, out of range on the small one
        data_in = 8'h77;
        xact(1'b0, 2'd3, 17'h00789, 8'h00, 1'b0);
        check("t3_cs_value", cs_seen, 3'b011);
        check("t3_rdata", rd_done, 8'h77);
        check("ill_strobes", s_stb, 0);
        check("ill_done_cnt", s_done_cnt, 1);
        check("ill_rdata", s_rd, 8'h00);

        // request raised in HOLD: burst follow-on, or ignored
        xact(1'b1, 2'd0, 17'h00100, 8'h11, 1'b1);
        check("burst_done_cnt", done_cnt, BURST ? 2 : 1);
        check("burst_done2_at", done2, BURST ? 15 : -1);
        check("burst_be_first", be_first, BURST ? 17 : 10);
        check("burst_we_lo", we_lo, BURST ? 8 : 4);

        // asynchronous reset in the middle of a strobe
        wait_ready();
        start = 1'b1; we = 1'b1; target = 2'd1; addr = 17'h0F0F0; wdata = 8'h99;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_strobe_cs", cs_n, 3'b110);
        #1 rst_n = 1'b0;
        #1 check_reset_pins("async");
        repeat (2) @(posedge clk);
        release_reset();

        // RAM read after recovery
        data_in = 8'hC3;
        xact(1'b0, 2'd0, 17'h1FFFF, 8'h00, 1'b0);
        check("rd_oe_lo_cycles", oe_lo, 4);
        check("rd_rdata", rd_done, 8'hC3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
